// File: rtl/recurrence_pkg.sv
// -----------------------------------------------------------------------------
// recurrence_pkg
//   Shared types and constants for the second-order recurrence engine
//   f(n) = A*f(n-1) + B*f(n-2).
//   - state_e    : controller states
//   - DEF_*_C    : power-up coefficients and seeds (A=2, B=3, f0=1, f1=1)
//   - sum_width(): width that holds A*x + B*y without loss
// -----------------------------------------------------------------------------
package recurrence_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    COMPUTE = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam int DEF_A_C  = 2;
  localparam int DEF_B_C  = 3;
  localparam int DEF_F0_C = 1;
  localparam int DEF_F1_C = 1;

  // Each product needs COEF_W+VAL_W bits; adding two of them needs one more.
  function automatic int sum_width(input int val_w, input int coef_w);
    return coef_w + val_w + 1;
  endfunction

endpackage

// File: rtl/recurrence_mac.sv
// -----------------------------------------------------------------------------
// recurrence_mac
//   Combinational multiply-accumulate a*x + b*y.
//   Ports:
//     a_i, b_i   [COEF_W-1:0]  coefficients
//     x_i, y_i   [VAL_W-1:0]   operands (f(k-1), f(k-2))
//     sum_o      [VAL_W-1:0]   full sum modulo 2^VAL_W
//     carry_o                  full sum did not fit in VAL_W bits
// -----------------------------------------------------------------------------
module recurrence_mac
  import recurrence_pkg::*;
#(
  parameter int VAL_W  = 8,
  parameter int COEF_W = 4
) (
  input  logic [COEF_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  input  logic [VAL_W-1:0]  x_i,
  input  logic [VAL_W-1:0]  y_i,
  output logic [VAL_W-1:0]  sum_o,
  output logic              carry_o
);

  localparam int SUM_W = sum_width(VAL_W, COEF_W);

  logic [SUM_W-1:0] full_sum;

  // Operands widened first so the products are evaluated at full width.
  assign full_sum = (SUM_W'(a_i) * SUM_W'(x_i)) + (SUM_W'(b_i) * SUM_W'(y_i));
  assign sum_o    = full_sum[VAL_W-1:0];
  assign carry_o  = |full_sum[SUM_W-1:VAL_W];

endmodule

// File: rtl/recurrence_engine.sv
// -----------------------------------------------------------------------------
// recurrence_engine
//   Memoised bottom-up evaluator of f(n) = A*f(n-1) + B*f(n-2), f(0)=F0,
//   f(1)=F1. Computed entries persist between queries; a miss extends the
//   table one entry per cycle starting just above the highest valid index.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start, entry      query request (IDLE only) and requested n
//     cfg_we, cfg_*     load A, B, f(0), f(1) (IDLE only, wins over start)
//     busy              controller not in IDLE
//     done              one-cycle response pulse
//     result            f(n) mod 2^VAL_W, held until the next response
//     overflow          true f(n) (or any predecessor) exceeded VAL_W bits
//     err               requested n was >= DEPTH
// -----------------------------------------------------------------------------
module recurrence_engine
  import recurrence_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int DEPTH  = 16,
  parameter int VAL_W  = 8,
  parameter int COEF_W = 4,
  parameter int DEF_A  = DEF_A_C,
  parameter int DEF_B  = DEF_B_C,
  parameter int DEF_F0 = DEF_F0_C,
  parameter int DEF_F1 = DEF_F1_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  entry,
  input  logic              cfg_we,
  input  logic [COEF_W-1:0] cfg_a,
  input  logic [COEF_W-1:0] cfg_b,
  input  logic [VAL_W-1:0]  cfg_f0,
  input  logic [VAL_W-1:0]  cfg_f1,
  output logic              busy,
  output logic              done,
  output logic [VAL_W-1:0]  result,
  output logic              overflow,
  output logic              err
);

  // Table address width; entry may be wider than needed to address DEPTH rows.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [COEF_W-1:0]   a_q, b_q;
  logic [VAL_W-1:0]    table_q [DEPTH];
  logic [DEPTH-1:0]    ovf_q;
  logic [IDX_W-1:0]    hi_q, k_q, n_q;
  logic [VAL_W-1:0]    result_q;
  logic                overflow_q, err_q;

  logic                entry_oob;
  logic [AW-1:0]       k_a, km1_a, km2_a, n_a;
  logic [VAL_W-1:0]    mac_sum;
  logic                mac_carry, new_ovf;

  assign entry_oob = {1'b0, entry} >= DEPTH_X;

  // n < DEPTH is established before COMPUTE/LOOKUP, so truncating to the
  // table address width never aliases a live index.
  assign k_a   = AW'(k_q);
  assign km1_a = AW'(k_q - 1'b1);
  assign km2_a = AW'(k_q - 2'd2);
  assign n_a   = AW'(n_q);

  recurrence_mac #(
    .VAL_W  (VAL_W),
    .COEF_W (COEF_W)
  ) u_mac (
    .a_i     (a_q),
    .b_i     (b_q),
    .x_i     (table_q[km1_a]),
    .y_i     (table_q[km2_a]),
    .sum_o   (mac_sum),
    .carry_o (mac_carry)
  );

  // Overflow is sticky along the chain: once any predecessor wrapped, every
  // later entry is derived from wrapped data.
  assign new_ovf = ovf_q[km1_a] | ovf_q[km2_a] | mac_carry;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!cfg_we && start) begin
          if (entry_oob)          state_d = RESPOND;
          else if (entry <= hi_q) state_d = LOOKUP;
          else                    state_d = COMPUTE;
        end
      end
      LOOKUP:  state_d = RESPOND;
      COMPUTE: if (k_q == n_q) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= COEF_W'(DEF_A);
      b_q        <= COEF_W'(DEF_B);
      // NOTE: only the two seed rows are reset; rows above hi are never read
      // before being written, so clearing them would only add reset fan-out.
      table_q[0] <= VAL_W'(DEF_F0);
      table_q[1] <= VAL_W'(DEF_F1);
      ovf_q      <= '0;
      hi_q       <= IDX_W'(1);
      k_q        <= '0;
      n_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (cfg_we) begin
            a_q        <= cfg_a;
            b_q        <= cfg_b;
            table_q[0] <= cfg_f0;
            table_q[1] <= cfg_f1;
            ovf_q      <= '0;
            hi_q       <= IDX_W'(1);
          end else if (start) begin
            n_q <= entry;
            k_q <= hi_q + 1'b1;
            if (entry_oob) begin
              result_q   <= '0;
              overflow_q <= 1'b0;
              err_q      <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          result_q   <= table_q[n_a];
          overflow_q <= ovf_q[n_a];
          err_q      <= 1'b0;
        end
        COMPUTE: begin
          table_q[k_a] <= mac_sum;
          ovf_q[k_a]   <= new_ovf;
          hi_q         <= k_q;
          k_q          <= k_q + 1'b1;
          if (k_q == n_q) begin
            result_q   <= mac_sum;
            overflow_q <= new_ovf;
            err_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == RESPOND);
  assign result   = result_q;
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule
